// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four clients and the round-robin arbiter.
// Clients drive req; the arbiter returns a one-hot grant and its index.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with bounded hold time per grant.
// Grant index is registered; gnt is its 2-to-4 decode gated by valid.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX =
    CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [1:0]       last_q;
  logic [1:0]       last_d;
  logic             valid_q;
  logic             valid_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [3:0] own_bit;
  logic [3:0] others;
  logic [3:0] cand;
  logic       owner_req;
  logic       at_max;
  logic       win_any;
  logic [1:0] win_idx;

  // First set bit of r searching base+1, base+2, base+3, base (mod 4).
  function automatic logic [2:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] base
  );
    logic [2:0] res;
    logic [1:0] pos;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      pos = base + 2'(k);
      if (r[pos]) begin
        res = {1'b1, pos};
      end
    end
    return res;
  endfunction

  assign own_bit   = 4'b0001 << idx_q;
  assign others    = bus.req & ~own_bit;
  assign owner_req = |(bus.req & own_bit);
  assign at_max    = (cnt_q >= HOLD_MAX);

  // While granted, last_q equals the owner, so masking the owner
  // and searching from last_q never re-picks the owner.
  assign cand = (state_q == GRANT) ? others : bus.req;

  always_comb begin
    logic [2:0] pick;
    pick    = rr_pick(cand, last_q);
    win_any = pick[2];
    win_idx = pick[1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = GRANT;
          idx_d   = win_idx;
          last_d  = win_idx;
          valid_d = 1'b1;
          cnt_d   = CNT_ONE;
        end
      end
      GRANT: begin
        unique case (1'b1)
          (!owner_req && win_any),
          (owner_req && at_max && win_any): begin
            idx_d   = win_idx;
            last_d  = win_idx;
            valid_d = 1'b1;
            cnt_d   = CNT_ONE;
          end
          (!owner_req && !win_any): begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
          (owner_req && !at_max): begin
            cnt_d = cnt_q + CNT_ONE;
          end
          (owner_req && at_max && !win_any): begin
            cnt_d = CNT_ONE;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.gnt = 4'b0000;
    if (valid_q) begin
      unique case (idx_q)
        2'd0:    bus.gnt = 4'b0001;
        2'd1:    bus.gnt = 4'b0010;
        2'd2:    bus.gnt = 4'b0100;
        default: bus.gnt = 4'b1000;
      endcase
    end
  end

  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and random checks of rr_arbiter4 against a
// behavioural round-robin model.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;
  localparam int WAIT_MAX = 3 * MAX_HOLD + 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  int   m_valid;
  int   m_idx;
  int   m_last;
  int   m_cnt;
  int   wait_c [4];

  rr_arbiter4_if arb_if ();

  rr_arbiter4 #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic rr(
    input  logic [3:0] r,
    input  int         base,
    output int         w
  );
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (base + k) % 4;
      if (r[i] && w < 0) w = i;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    logic [3:0] oth;
    if (!rst_n) begin
      m_valid = 0;
      m_idx   = 0;
      m_last  = 3;
      m_cnt   = 0;
    end else if (m_valid == 0) begin
      rr(r, m_last, w);
      if (w >= 0) begin
        m_valid = 1;
        m_idx   = w;
        m_last  = w;
        m_cnt   = 1;
      end
    end else begin
      oth = r;
      oth[m_idx] = 1'b0;
      rr(oth, m_idx, w);
      if (!r[m_idx]) begin
        if (w >= 0) begin
          m_idx  = w;
          m_last = w;
          m_cnt  = 1;
        end else begin
          m_valid = 0;
          m_cnt   = 0;
        end
      end else if (m_cnt < MAX_HOLD) begin
        m_cnt++;
      end else if (w >= 0) begin
        m_idx  = w;
        m_last = w;
        m_cnt  = 1;
      end else begin
        m_cnt = 1;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] r;
    logic [3:0] e_gnt;
    logic [3:0] dec;
    r = arb_if.req;
    model_step(r);
    @(posedge clk);
    #1;
    e_gnt = (m_valid != 0) ? 4'(1 << m_idx) : 4'b0000;
    chk("gnt", 32'(arb_if.gnt), 32'(e_gnt));
    chk("gnt_idx", 32'(arb_if.gnt_idx), 32'(m_idx));
    chk("gnt_valid", 32'(arb_if.gnt_valid), 32'(m_valid));
    chk("onehot", 32'($countones(arb_if.gnt) <= 1), 32'd1);
    dec = arb_if.gnt_valid ? 4'(1 << arb_if.gnt_idx) : 4'b0000;
    chk("decode", 32'(arb_if.gnt), 32'(dec));
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || !r[i] || e_gnt[i]) wait_c[i] = 0;
      else wait_c[i]++;
      if (wait_c[i] > WAIT_MAX)
        chk($sformatf("wait%0d", i), 32'(wait_c[i]), 32'(WAIT_MAX));
    end
  endtask

  initial begin
    logic [3:0] tg;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4; i++) wait_c[i] = 0;
    m_valid = 0;
    m_idx   = 0;
    m_last  = 3;
    m_cnt   = 0;
    rst_n      = 1'b0;
    arb_if.req = 4'b1111;
    tick();
    tick();
    chk("rst_gnt", 32'(arb_if.gnt), 32'h0);
    chk("rst_valid", 32'(arb_if.gnt_valid), 32'h0);

    rst_n = 1'b1;
    for (int n = 0; n <= 32; n++) begin
      tick();
      chk($sformatf("rot%0d", n), 32'(arb_if.gnt),
          32'(1 << ((n / 8) % 4)));
    end

    arb_if.req = 4'b0000;
    tick();
    arb_if.req = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("short_hold", 32'(arb_if.gnt), 32'h4);
    end
    arb_if.req = 4'b0000;
    tick();
    chk("release_gnt", 32'(arb_if.gnt), 32'h0);
    chk("release_idx", 32'(arb_if.gnt_idx), 32'h2);

    arb_if.req = 4'b0010;
    tick();
    chk("b2b_own1", 32'(arb_if.gnt), 32'h2);
    arb_if.req = 4'b1001;
    tick();
    chk("b2b_to3", 32'(arb_if.gnt), 32'h8);

    arb_if.req = 4'b0000;
    tick();
    arb_if.req = 4'b0001;
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("sole", 32'(arb_if.gnt), 32'h1);
    end

    arb_if.req = 4'b0000;
    tick();
    arb_if.req = 4'b0100;
    tick();
    chk("mid_pre", 32'(arb_if.gnt), 32'h4);
    rst_n = 1'b0;
    tick();
    chk("mid_rst", 32'(arb_if.gnt), 32'h0);
    rst_n      = 1'b1;
    arb_if.req = 4'b0101;
    tick();
    chk("mid_ptr", 32'(arb_if.gnt), 32'h1);

    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < 4; b++)
        tg[b] = ($urandom_range(0, 3) == 0);
      arb_if.req = arb_if.req ^ tg;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter for one shared resource.
- The grant index is held in a register and decoded 2-to-4 into a one-hot grant vector. This is the same decode the team's decoder2to4 blocks perform.
- Sits between four client FSMs and a shared resource such as a bus, memory port or ALU.
- Enforces fairness and a bounded hold time per grant.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles a requester may hold the grant while others wait (legal range 1..255)
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req  input  4  request vector, bit i = requester i wants the resource; level-sensitive
gnt  output  4  one-hot grant, registered; 4'b0000 when no grant
gnt_idx  output  2  binary index of current/last grant, registered
gnt_valid  output  1  high when gnt is non-zero

Behaviour:
- Reset (rst_n low at a clock edge):
  - gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0.
  - Internal last pointer=2'd3, so requester 0 has top priority first.
  - Hold counter=0, state=IDLE.
  - Reset dominates all other inputs, including mid-grant: the grant drops on that edge.
- gnt is always the 2-to-4 decode of gnt_idx gated by gnt_valid; no other gnt values are legal.
- State IDLE:
  - If req==0, remain in IDLE; outputs stay zero except gnt_idx, which keeps the last winner.
  - If req!=0, the winner is the first set bit searching last+1, last+2, last+3, last (mod 4).
  - On the next edge: gnt_idx=winner, gnt_valid=1, last=winner, counter=1, go to GRANT.
  - Latency from req sampled high to gnt high is 1 cycle.
- State GRANT (owner = gnt_idx):
  - req[owner]=0 (release), other requests pending: re-arbitrate on the same edge, excluding the owner by rotation. The new grant appears the next cycle with no dead cycle (back-to-back).
  - req[owner]=0, no other requests pending: go to IDLE; gnt=0, gnt_valid=0 on that edge.
  - req[owner]=1, counter<MAX_HOLD: keep the grant and increment the counter.
  - req[owner]=1, counter==MAX_HOLD, some other req bit set: forced preemption. Grant moves to the next round-robin winner (never the owner) on that edge; counter=1.
  - req[owner]=1, counter==MAX_HOLD, no other req: keep the grant; counter restarts at 1 (saturates, no wrap).
- The pointer wraps 3→0 in the search order.
- Simultaneous release and new requests are resolved in the same cycle as described above.
- Requests that appear and vanish between edges are not seen (sampled only).
- No combinational path from req to gnt.
- Invariants:
  - popcount(gnt) ≤ 1.
  - gnt_valid == |gnt.
  - A pending requester waits at most 3×MAX_HOLD cycles plus 3 cycles.

Test Plan:
- Reset with req=4'b1111, rst_n=0 for 2 cycles → gnt=0000, gnt_valid=0. Release with req=1111 held → gnt=0001 on the 1st edge. With MAX_HOLD=8, after 8 cycles gnt goes 0010, then 0100, then 1000, then 0001; each grant lasts exactly 8 cycles.
- req=4'b0100 held 3 cycles, then 0 → gnt=0100 from cycle 1 to cycle 3. On the first edge sampling req=0, gnt=0000 and state returns to IDLE.
- Back-to-back: owner 1 holds gnt=0010, then req changes 0010→1001 → next edge gnt=1000. Requester 3 is next after 1 in the rotation (2 is idle); no zero cycle between the grants.
- Sole requester: req=0001 held for 20 cycles with MAX_HOLD=8 → gnt=0001 continuously. The counter restarts at 1 after reaching 8, and gnt never drops.
- Reset mid-grant: gnt=0100, rst_n pulled low one cycle → gnt=0000 on that edge. Afterward, with req=0101, gnt=0001, showing the pointer was reset to 3.
- Random req for 2000 cycles → checker confirms popcount(gnt)≤1, gnt == decode(gnt_idx) & {4{gnt_valid}}, and maximum wait ≤ 27 cycles (MAX_HOLD=8).
